mem_port_arbiter: RTL and testbench

- Shares one simple-dual-port synchronous RAM (one read port, one write port, 1-cycle registered read) between two requesters:
  - the instruction-fetch unit (IF), which is read-only;
  - the load/store unit (LS), which can read or write.
- Sits between the CPU front-end/LSU and the data/instruction RAM instance.
- Arbitrates the single read port round-robin and routes read data back with a registered owner tag.
- Blocks reads that collide with a same-cycle write to the same address, because the RAM returns old data in that case.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a simple-dual-port synchronous RAM.
// The instruction-fetch (IF) port is read-only; the load/store (LS) port reads
// or writes. The single RAM read port is shared round-robin. A read that hits
// the address being written in the same cycle is held off for one cycle,
// because the RAM would return the old word. Read data comes back one cycle
// after the grant, steered by a registered owner tag.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [ADDR_WIDTH-1:0] ram_read_address,
    output logic [ADDR_WIDTH-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_e;

    logic   ls_wr_s;
    logic   if_cand_s;
    logic   ls_cand_s;
    logic   if_rd_gnt_s;
    logic   ls_rd_gnt_s;
    req_e   last_rd_r;
    req_e   last_rd_nxt_s;
    owner_e owner_r;
    owner_e owner_nxt_s;

    // Grant decision: writes always go, reads are masked on a same-address
    // write, and two live read candidates are split by the round-robin pointer.
    always_comb begin
        ls_wr_s       = ls_req & ls_we;
        if_cand_s     = if_req & ~(ls_wr_s & (if_addr == ls_addr));
        ls_cand_s     = ls_req & ~ls_we;
        if_rd_gnt_s   = 1'b0;
        ls_rd_gnt_s   = 1'b0;
        last_rd_nxt_s = last_rd_r;
        owner_nxt_s   = OWN_NONE;
        if (if_cand_s && ls_cand_s) begin
            if (last_rd_r == REQ_LS) begin
                if_rd_gnt_s = 1'b1;
            end else begin
                ls_rd_gnt_s = 1'b1;
            end
        end else begin
            if_rd_gnt_s = if_cand_s;
            ls_rd_gnt_s = ls_cand_s;
        end
        if (if_rd_gnt_s) begin
            last_rd_nxt_s = REQ_IF;
            owner_nxt_s   = OWN_IF;
        end else if (ls_rd_gnt_s) begin
            last_rd_nxt_s = REQ_LS;
            owner_nxt_s   = OWN_LS;
        end else begin
            last_rd_nxt_s = last_rd_r;
            owner_nxt_s   = OWN_NONE;
        end
    end

    // RAM-side and grant outputs; idle address/data buses are parked at zero.
    always_comb begin
        if_gnt            = if_rd_gnt_s;
        ls_gnt            = ls_wr_s | ls_rd_gnt_s;
        ram_write         = ls_wr_s;
        ram_write_address = {ADDR_WIDTH{1'b0}};
        ram_din           = {DATA_WIDTH{1'b0}};
        ram_read_address  = {ADDR_WIDTH{1'b0}};
        if (ls_wr_s) begin
            ram_write_address = ls_addr;
            ram_din           = ls_wdata;
        end else begin
            ram_write_address = {ADDR_WIDTH{1'b0}};
            ram_din           = {DATA_WIDTH{1'b0}};
        end
        if (if_rd_gnt_s) begin
            ram_read_address = if_addr;
        end else if (ls_rd_gnt_s) begin
            ram_read_address = ls_addr;
        end else begin
            ram_read_address = {ADDR_WIDTH{1'b0}};
        end
    end

    // Round-robin pointer and owner tag of the read in flight; reset drops it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_rd_r <= REQ_LS;
            owner_r   <= OWN_NONE;
        end else begin
            last_rd_r <= last_rd_nxt_s;
            owner_r   <= owner_nxt_s;
        end
    end

    // Steer the RAM output to the owner of the previous cycle's read.
    always_comb begin
        if_rvalid = (owner_r == OWN_IF);
        ls_rvalid = (owner_r == OWN_LS);
        if_rdata  = {DATA_WIDTH{1'b0}};
        ls_rdata  = {DATA_WIDTH{1'b0}};
        if (owner_r == OWN_IF) begin
            if_rdata = ram_dout;
        end else if (owner_r == OWN_LS) begin
            ls_rdata = ram_dout;
        end else begin
            if_rdata = {DATA_WIDTH{1'b0}};
            ls_rdata = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a RAM model, a directed vector table, hand
// sequences for the multi-cycle cases and a randomized run against a
// rule-based reference model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [3:0]  if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [3:0]  ram_read_address;
    logic [3:0]  ram_write_address;
    logic        ram_write;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] mem [16];

    int total;
    int bad;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple-dual-port RAM: old data is returned on a same-address write.
    always @(posedge clk) begin
        if (ram_write) mem[ram_write_address] <= ram_din;
        ram_dout <= mem[ram_read_address];
    end

    // Reference model state
    bit          m_last_ls;
    bit          m_if_rv, m_ls_rv;
    logic [31:0] m_if_d, m_ls_d;
    bit          m_if_g, m_ls_g;
    logic [31:0] ref_mem [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last_ls = 1'b1;
        m_if_rv   = 1'b0;
        m_ls_rv   = 1'b0;
        m_if_d    = 32'd0;
        m_ls_d    = 32'd0;
    endtask

    // Called between edges with inputs stable: optionally check, then advance.
    task automatic model_step(input bit chk_en);
        bit         wr, ifc, lsc, lsr;
        logic [3:0] ra;
        wr  = ls_req && ls_we;
        ifc = if_req && !(wr && (if_addr == ls_addr));
        lsc = ls_req && !ls_we;
        m_if_g = ifc && (!lsc || m_last_ls);
        lsr    = lsc && (!ifc || !m_last_ls);
        m_ls_g = wr || lsr;
        ra = m_if_g ? if_addr : (lsr ? ls_addr : 4'd0);
        if (chk_en) begin
            chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_if_rv});
            chk("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, m_ls_rv});
            chk("if_rdata", if_rdata, m_if_rv ? m_if_d : 32'd0);
            chk("ls_rdata", ls_rdata, m_ls_rv ? m_ls_d : 32'd0);
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, m_if_g});
            chk("ls_gnt", {31'd0, ls_gnt}, {31'd0, m_ls_g});
            chk("ram_write", {31'd0, ram_write}, {31'd0, wr});
            chk("ram_read_address", {28'd0, ram_read_address}, {28'd0, ra});
            chk("ram_write_address", {28'd0, ram_write_address}, wr ? {28'd0, ls_addr} : 32'd0);
            chk("ram_din", ram_din, wr ? ls_wdata : 32'd0);
        end
        m_if_rv = m_if_g;
        m_ls_rv = lsr;
        m_if_d  = ref_mem[if_addr];
        m_ls_d  = ref_mem[ls_addr];
        if (m_if_g) m_last_ls = 1'b0;
        else if (lsr) m_last_ls = 1'b1;
        if (wr) ref_mem[ls_addr] = ls_wdata;
    endtask

    task automatic set_in(input bit ir, input logic [3:0] ia, input bit lr, input bit lw,
                          input logic [3:0] la, input logic [31:0] ld);
        if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = ld;
    endtask

    // One fully model-checked cycle with the current inputs.
    task automatic cycle_chk();
        @(negedge clk);
        model_step(1'b1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        if_req;
        logic [3:0]  if_addr;
        logic        ls_req;
        logic        ls_we;
        logic [3:0]  ls_addr;
        logic [31:0] ls_wdata;
        logic        e_if_gnt;
        logic        e_ls_gnt;
        logic        e_wr;
        logic [3:0]  e_raddr;
        logic        e_if_rv;
        logic        e_ls_rv;
    } vec_t;

    vec_t vecs [8];

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end

        //              ir   ia    lr   lw   la    wdata          ig   lg   wr   ra    irv  lrv
        vecs[0] = '{1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0,        1'b0,1'b0,1'b0,4'd0, 1'b0,1'b0};
        vecs[1] = '{1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 32'h0,        1'b1,1'b0,1'b0,4'd3, 1'b0,1'b0};
        vecs[2] = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd2, 32'h0,        1'b0,1'b1,1'b0,4'd2, 1'b1,1'b0};
        vecs[3] = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd2, 32'h0,        1'b1,1'b0,1'b0,4'd1, 1'b0,1'b1};
        vecs[4] = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd2, 32'h0,        1'b0,1'b1,1'b0,4'd2, 1'b1,1'b0};
        vecs[5] = '{1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 32'h5555_AAAA,1'b0,1'b1,1'b1,4'd0, 1'b0,1'b1};
        vecs[6] = '{1'b1, 4'd5, 1'b1, 1'b1, 4'd7, 32'h7777_0000,1'b1,1'b1,1'b1,4'd5, 1'b0,1'b0};
        vecs[7] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 32'h0,        1'b0,1'b1,1'b0,4'd6, 1'b1,1'b0};

        // Reset and idle
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("reset_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        for (int i = 0; i < 5; i++) cycle_chk();

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            set_in(vecs[i].if_req, vecs[i].if_addr, vecs[i].ls_req, vecs[i].ls_we,
                   vecs[i].ls_addr, vecs[i].ls_wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_if_gnt", i), {31'd0, if_gnt}, {31'd0, vecs[i].e_if_gnt});
            chk($sformatf("vec%0d_ls_gnt", i), {31'd0, ls_gnt}, {31'd0, vecs[i].e_ls_gnt});
            chk($sformatf("vec%0d_ram_write", i), {31'd0, ram_write}, {31'd0, vecs[i].e_wr});
            chk($sformatf("vec%0d_raddr", i), {28'd0, ram_read_address}, {28'd0, vecs[i].e_raddr});
            chk($sformatf("vec%0d_if_rvalid", i), {31'd0, if_rvalid}, {31'd0, vecs[i].e_if_rv});
            chk($sformatf("vec%0d_ls_rvalid", i), {31'd0, ls_rvalid}, {31'd0, vecs[i].e_ls_rv});
            model_step(1'b0);
            @(posedge clk);
            #1;
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle_chk();

        // IF read of a known word
        set_in(1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
        cycle_chk();
        set_in(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("rd3_if_gnt", {31'd0, if_gnt}, 32'd1);
        model_step(1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("rd3_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("rd3_if_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("rd3_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        model_step(1'b0);
        @(posedge clk); #1;

        // Write/read collision on address 5
        set_in(1'b1, 4'd5, 1'b1, 1'b1, 4'd5, 32'h1234_5678);
        @(negedge clk);
        chk("col_n_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        chk("col_n_if_gnt", {31'd0, if_gnt}, 32'd0);
        model_step(1'b0);
        @(posedge clk); #1;
        set_in(1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("col_n1_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("col_n1_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        model_step(1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("col_n2_if_rdata", if_rdata, 32'h1234_5678);
        model_step(1'b0);
        @(posedge clk); #1;

        // LS write 7 and IF read 4 together
        set_in(1'b1, 4'd4, 1'b1, 1'b1, 4'd7, 32'hCAFE_0007);
        @(negedge clk);
        chk("par_if_gnt", {31'd0, if_gnt}, 32'd1);
        chk("par_ls_gnt", {31'd0, ls_gnt}, 32'd1);
        chk("par_ram_write", {31'd0, ram_write}, 32'd1);
        chk("par_raddr", {28'd0, ram_read_address}, 32'd4);
        model_step(1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("par_if_rdata", if_rdata, 32'h1000_0004);
        model_step(1'b0);
        @(posedge clk); #1;

        // Continuous LS writes with IF reading other addresses
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, i[3:0], 1'b1, 1'b1, 4'd8 + i[3:0], 32'hA000_0000 + i);
            @(negedge clk);
            chk($sformatf("stream%0d_if_gnt", i), {31'd0, if_gnt}, 32'd1);
            model_step(1'b0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 9; i++) begin
            if (i < 8) set_in(1'b1, 4'd8 + i[3:0], 1'b0, 1'b0, 4'd0, 32'd0);
            else       set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
            @(negedge clk);
            if (i > 0) chk($sformatf("readback%0d", i - 1), if_rdata, 32'hA000_0000 + (i - 1));
            model_step(1'b0);
            @(posedge clk); #1;
        end

        // Reset while a read is in flight
        set_in(1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 32'd0);
        @(negedge clk);
        chk("rst_mid_if_gnt", {31'd0, if_gnt}, 32'd1);
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        chk("rst_mid_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("rst_mid_ls_rvalid", {31'd0, ls_rvalid}, 32'd0);
        reset = 1'b0;
        cycle_chk();

        // Randomized traffic, requests held until the model says granted
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            model_step(1'b1);
            @(posedge clk); #1;
            if (!if_req || m_if_g) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = 4'($urandom_range(0, 15));
            end
            if (!ls_req || m_ls_g) begin
                ls_req   = ($urandom_range(0, 3) != 0);
                ls_we    = ($urandom_range(0, 1) != 0);
                ls_addr  = 4'($urandom_range(0, 15));
                ls_wdata = $urandom;
            end
        end
        set_in(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'd0);
        cycle_chk();
        cycle_chk();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
